// File: rtl/i2c_target_if.sv
// i2c_target_if: register-file port between the I2C target and its register block
interface i2c_target_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_target.sv
// i2c_target: I2C target bridging bus bytes to a pointer-addressed register port
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  output logic sda_oe,
  output logic busy,
  i2c_target_if.master rb
);
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_MACK, ST_IGNORE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_d, sda_d, scl_n, sda_n;
  logic scl_rise, scl_fall, start, stop;
  logic [3:0] bit_cnt;
  logic [7:0] shift, tx_shift, ptr, wdata;
  logic rw, first_byte, load, we, re;
  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl_n = scl_s[SYNC_STAGES-1];
  assign sda_n = sda_s[SYNC_STAGES-1];
  assign scl_rise = scl_n & ~scl_d;
  assign scl_fall = ~scl_n & scl_d;
  assign start = scl_n & scl_d & sda_d & ~sda_n;
  assign stop = scl_n & scl_d & ~sda_d & sda_n;
  assign rb.reg_addr = ptr;
  assign rb.reg_wdata = wdata;
  assign rb.reg_we = we;
  assign rb.reg_re = re;
  // pin synchronisers and edge history; reset to an idle (high) bus so no false START
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda};
      scl_d <= scl_n;
      sda_d <= sda_n;
    end
  // protocol FSM with registered SDA drive, strobes and pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      bit_cnt <= '0;
      shift <= '0;
      tx_shift <= '0;
      ptr <= '0;
      wdata <= '0;
      rw <= 1'b0;
      first_byte <= 1'b0;
      load <= 1'b0;
      we <= 1'b0;
      re <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
    end else begin
      we <= 1'b0;
      re <= 1'b0;
      load <= re;
      if (we | re) ptr <= ptr + 8'd1;
      if (load) tx_shift <= rb.reg_rdata;
      if (start) begin
        state <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (stop) begin
        state <= ST_IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_RX:
            if (scl_rise) begin
              shift <= {shift[6:0], sda_n};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ST_RX) begin
                sda_oe <= 1'b1;
                state <= ST_RX_ACK;
                first_byte <= 1'b0;
                if (first_byte) ptr <= shift;
                else begin
                  we <= 1'b1;
                  wdata <= shift;
                end
              end else if (shift[7:1] == ADDR && |shift[7:1]) begin
                sda_oe <= 1'b1;
                busy <= 1'b1;
                rw <= shift[0];
                state <= ST_ADDR_ACK;
              end else state <= ST_IGNORE;
            end
          ST_ADDR_ACK:
            if (scl_rise && rw) re <= 1'b1;
            else if (scl_fall) begin
              bit_cnt <= '0;
              sda_oe <= rw ? ~tx_shift[7] : 1'b0;
              state <= rw ? ST_TX : ST_RX;
              first_byte <= ~rw;
            end
          ST_RX_ACK:
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state <= ST_RX;
            end
          ST_TX:
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe <= 1'b0;
                state <= ST_TX_MACK;
              end else begin
                sda_oe <= ~tx_shift[6];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          ST_TX_MACK:
            if (scl_rise) begin
              if (sda_n) begin
                state <= ST_IGNORE;
                busy <= 1'b0;
              end else re <= 1'b1;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              sda_oe <= ~tx_shift[7];
              state <= ST_TX;
            end
          default: ;
        endcase
      end
    end
endmodule
